actuator_uart_core: RTL and testbench

//  - MMIO slot UART serving one actuator serial channel (prx/ptx pair) inside mmio_sys_vanilla.
//  - Sits downstream of the bridge/MMIO decoder and upstream of the pins.
//  - Buffers CPU bytes in a TX FIFO and serialises them as 8N1 (or 8E1).
//  - Deserialises RX into an RX FIFO; programmable baud via 16x oversampling tick.

---
 rtl/actuator_uart_core.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_actuator_uart_core.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/actuator_uart_core.sv
// MMIO slot UART for one actuator serial channel: TX/RX FIFOs, 16x oversampled baud tick, 8N1 framing.
// Optional macro PARITY_EN adds an even-parity bit to both directions (8E1) and the parity_err flag.
module actuator_uart_core #(
    parameter int unsigned DBIT     = 8,
    parameter int unsigned SB_TICK  = 16,
    parameter int unsigned FIFO_W   = 4,
    parameter int unsigned DVSR_RST = 650
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    input  logic        rx,
    output logic        tx
);

`ifdef PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    localparam int unsigned DEPTH = 1 << FIFO_W;
    localparam int unsigned CW    = FIFO_W + 1;
    localparam int unsigned DW    = 11;
    localparam int unsigned NW    = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int unsigned TW    = $clog2((SB_TICK > 16) ? SB_TICK : 16);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    logic wr_en, dvsr_wr, tx_push, rx_pop, flag_clr;
    logic unused_bits;

    assign wr_en       = cs & write;
    assign dvsr_wr     = wr_en && (addr == 5'd1);
    assign tx_push     = wr_en && (addr == 5'd2);
    assign rx_pop      = wr_en && (addr == 5'd3);
    assign flag_clr    = wr_en && (addr == 5'd4);
    assign unused_bits = &{1'b0, wr_data[31:DW]};

    // Baud tick: one cycle every dvsr+1 clocks
    logic [DW-1:0] dvsr, cnt;
    logic          tick;

    assign tick = (cnt == dvsr);

    always_ff @(posedge clk) begin
        if (reset) begin
            dvsr <= DW'(DVSR_RST);
            cnt  <= '0;
        end else if (dvsr_wr) begin
            dvsr <= wr_data[DW-1:0];
            cnt  <= '0;
        end else begin
            cnt  <= tick ? '0 : cnt + DW'(1);
        end
    end

    // TX FIFO
    logic [7:0]        tx_mem [DEPTH];
    logic [FIFO_W-1:0] tx_wp, tx_rp;
    logic [CW-1:0]     tx_cnt;
    logic              tx_full, tx_fempty, tx_pop, tx_push_ok, tx_pop_ok;
    logic [7:0]        tx_head;

    assign tx_full    = (tx_cnt == CW'(DEPTH));
    assign tx_fempty  = (tx_cnt == '0);
    assign tx_push_ok = tx_push & ~tx_full;
    assign tx_pop_ok  = tx_pop & ~tx_fempty;
    assign tx_head    = tx_mem[tx_rp];

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push_ok) tx_wp <= tx_wp + FIFO_W'(1);
            if (tx_pop_ok)  tx_rp <= tx_rp + FIFO_W'(1);
            tx_cnt <= tx_cnt + CW'(tx_push_ok) - CW'(tx_pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push_ok) tx_mem[tx_wp] <= wr_data[7:0];
    end

    // RX FIFO
    logic [DBIT-1:0]   rx_mem [DEPTH];
    logic [FIFO_W-1:0] rx_wp, rx_rp;
    logic [CW-1:0]     rx_cnt;
    logic              rx_full, rx_fempty, rx_done, rx_push_ok, rx_pop_ok;
    logic [7:0]        rx_head;
    logic [DBIT-1:0]   rx_b;

    assign rx_full    = (rx_cnt == CW'(DEPTH));
    assign rx_fempty  = (rx_cnt == '0);
    assign rx_push_ok = rx_done & ~rx_full;
    assign rx_pop_ok  = rx_pop & ~rx_fempty;
    assign rx_head    = rx_fempty ? 8'd0 : 8'(rx_mem[rx_rp]);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push_ok) rx_wp <= rx_wp + FIFO_W'(1);
            if (rx_pop_ok)  rx_rp <= rx_rp + FIFO_W'(1);
            rx_cnt <= rx_cnt + CW'(rx_push_ok) - CW'(rx_pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push_ok) rx_mem[rx_wp] <= rx_b;
    end

    // RX: 2-FF synchroniser, then start-bit mid-point check and centre sampling
    logic            rx_meta, rx_s;
    state_t          rx_state, rx_state_next;
    logic [TW-1:0]   rx_tc, rx_tc_next;
    logic [NW-1:0]   rx_n, rx_n_next;
    logic [DBIT-1:0] rx_b_next;
    logic            rx_pbad, rx_pbad_next, ferr_set, perr_set;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_state <= S_IDLE;
            rx_tc    <= '0;
            rx_n     <= '0;
            rx_b     <= '0;
            rx_pbad  <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rx_s     <= rx_meta;
            rx_state <= rx_state_next;
            rx_tc    <= rx_tc_next;
            rx_n     <= rx_n_next;
            rx_b     <= rx_b_next;
            rx_pbad  <= rx_pbad_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state;
        rx_tc_next    = rx_tc;
        rx_n_next     = rx_n;
        rx_b_next     = rx_b;
        rx_pbad_next  = rx_pbad;
        rx_done       = 1'b0;
        ferr_set      = 1'b0;
        perr_set      = 1'b0;
        case (rx_state)
            S_IDLE: if (!rx_s) begin
                rx_state_next = S_START;
                rx_tc_next    = '0;
            end
            S_START: if (tick) begin
                if (rx_tc == TW'(7)) begin
                    rx_state_next = rx_s ? S_IDLE : S_DATA;
                    rx_tc_next    = '0;
                    rx_n_next     = '0;
                    rx_pbad_next  = 1'b0;
                end else rx_tc_next = rx_tc + TW'(1);
            end
            S_DATA: if (tick) begin
                if (rx_tc == TW'(15)) begin
                    rx_tc_next = '0;
                    rx_b_next  = {rx_s, rx_b[DBIT-1:1]};
                    if (rx_n == NW'(DBIT - 1)) rx_state_next = PAR_EN ? S_PAR : S_STOP;
                    else                       rx_n_next     = rx_n + NW'(1);
                end else rx_tc_next = rx_tc + TW'(1);
            end
            S_PAR: if (tick) begin
                if (rx_tc == TW'(15)) begin
                    rx_tc_next    = '0;
                    rx_pbad_next  = rx_s ^ (^rx_b);
                    rx_state_next = S_STOP;
                end else rx_tc_next = rx_tc + TW'(1);
            end
            S_STOP: if (tick) begin
                if (rx_tc == TW'(SB_TICK - 1)) begin
                    rx_state_next = S_IDLE;
                    if (!rx_s)        ferr_set = 1'b1;
                    else if (rx_pbad) perr_set = 1'b1;
                    else              rx_done  = 1'b1;
                end else rx_tc_next = rx_tc + TW'(1);
            end
            default: rx_state_next = S_IDLE;
        endcase
    end

    // TX: pops on entry to START, so a queued byte follows the stop bit with no idle gap
    state_t          tx_state, tx_state_next;
    logic [TW-1:0]   tx_tc, tx_tc_next;
    logic [NW-1:0]   tx_n, tx_n_next;
    logic [7:0]      tx_b, tx_b_next;
    logic            tx_par, tx_par_next, tx_next, tx_load;

    assign tx_pop = tx_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= S_IDLE;
            tx_tc    <= '0;
            tx_n     <= '0;
            tx_b     <= '0;
            tx_par   <= 1'b0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_next;
            tx_tc    <= tx_tc_next;
            tx_n     <= tx_n_next;
            tx_b     <= tx_b_next;
            tx_par   <= tx_par_next;
            tx       <= tx_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state;
        tx_tc_next    = tx_tc;
        tx_n_next     = tx_n;
        tx_b_next     = tx_b;
        tx_par_next   = tx_par;
        tx_next       = 1'b1;
        tx_load       = 1'b0;
        case (tx_state)
            S_IDLE: tx_load = !tx_fempty;
            S_START: begin
                tx_next = 1'b0;
                if (tick) begin
                    if (tx_tc == TW'(15)) begin
                        tx_state_next = S_DATA;
                        tx_tc_next    = '0;
                        tx_n_next     = '0;
                    end else tx_tc_next = tx_tc + TW'(1);
                end
            end
            S_DATA: begin
                tx_next = tx_b[0];
                if (tick) begin
                    if (tx_tc == TW'(15)) begin
                        tx_tc_next = '0;
                        tx_b_next  = tx_b >> 1;
                        if (tx_n == NW'(DBIT - 1)) tx_state_next = PAR_EN ? S_PAR : S_STOP;
                        else                       tx_n_next     = tx_n + NW'(1);
                    end else tx_tc_next = tx_tc + TW'(1);
                end
            end
            S_PAR: begin
                tx_next = tx_par;
                if (tick) begin
                    if (tx_tc == TW'(15)) begin
                        tx_tc_next    = '0;
                        tx_state_next = S_STOP;
                    end else tx_tc_next = tx_tc + TW'(1);
                end
            end
            S_STOP: begin
                tx_next = 1'b1;
                if (tick) begin
                    if (tx_tc == TW'(SB_TICK - 1)) begin
                        tx_state_next = S_IDLE;
                        tx_load       = !tx_fempty;
                    end else tx_tc_next = tx_tc + TW'(1);
                end
            end
            default: tx_state_next = S_IDLE;
        endcase
        if (tx_load) begin
            tx_state_next = S_START;
            tx_tc_next    = '0;
            tx_b_next     = tx_head;
            tx_par_next   = ^tx_head;
        end
    end

    // Sticky status flags; a set in the same cycle as a clear wins
    logic overrun, frame_err, parity_err, tx_empty;

    assign tx_empty = tx_fempty && (tx_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            overrun    <= (rx_done & rx_full) | (overrun & ~flag_clr);
            frame_err  <= ferr_set | (frame_err & ~flag_clr);
            parity_err <= perr_set | (parity_err & ~flag_clr);
        end
    end

    always_comb begin
        rd_data = '0;
        if (cs && read && (addr == 5'd0))
            rd_data = {18'd0, parity_err, frame_err, tx_empty, overrun, tx_full, rx_fempty, rx_head};
    end

endmodule

// File: tb/tb_actuator_uart_core.sv
// Bench for actuator_uart_core: register map, TX serialisation via a line monitor, loopback, RX error cases.
module tb_actuator_uart_core;

`ifdef PARITY_EN
    localparam logic PAR = 1'b1;
`else
    localparam logic PAR = 1'b0;
`endif
    localparam int BIT_CLK = 64;

    logic        clk = 1'b0;
    logic        reset, cs, read, write, rx, tx, rx_drv, loop;
    logic [4:0]  addr;
    logic [31:0] wr_data, rd_data;

    assign rx = loop ? tx : rx_drv;
    always #5 clk = ~clk;

    actuator_uart_core dut (
        .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .rx(rx), .tx(tx)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    bit mon_en;
    bit mon_busy = 1'b0;
    int mon_frames = 0;

    typedef struct {
        logic [7:0] data;
        logic stop;
        logic bad_par;
        logic glitch;
        logic exp_push;
        logic exp_ferr;
        logic exp_perr;
    } rx_vec_t;
    rx_vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(posedge clk); #1;
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic reg_read(input logic [4:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        cs = 1'b1; read = 1'b1; addr = a;
        @(negedge clk);
        d = rd_data;
        #1;
        cs = 1'b0; read = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_q.push_back(b);
        reg_write(5'd2, {24'd0, b});
    endtask

    task automatic wait_tx_drain(input int budget);
        int k = 0;
        while ((tx_q.size() != 0 || mon_busy) && k < budget) begin
            @(posedge clk);
            k++;
        end
        check("tx_drain_in_time", 32'(k < budget), 32'd1);
        wait_clks(40);
    endtask

    // Serial frame onto rx_drv; a zero stop bit is held just past its centre, then released
    task automatic drive_frame(input logic [7:0] d, input logic stop, input logic bad_par);
        rx_drv = 1'b0;
        wait_clks(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            wait_clks(BIT_CLK);
        end
        if (PAR) begin
            rx_drv = (^d) ^ bad_par;
            wait_clks(BIT_CLK);
        end
        rx_drv = stop;
        wait_clks(stop ? BIT_CLK : 40);
        rx_drv = 1'b1;
        wait_clks(2 * BIT_CLK);
    endtask

    // Line monitor: decodes each tx frame at bit centres and scores it against tx_q
    initial begin
        forever begin
            logic [7:0] d;
            logic [7:0] e;
            logic st, sp, pb;
            bit en;
            @(negedge tx);
            en = mon_en;
            mon_busy = 1'b1;
            repeat (30) @(negedge clk);
            st = tx;
            for (int i = 0; i < 8; i++) begin
                repeat (BIT_CLK) @(negedge clk);
                d[i] = tx;
            end
            pb = 1'b0;
            if (PAR) begin
                repeat (BIT_CLK) @(negedge clk);
                pb = tx;
            end
            repeat (BIT_CLK) @(negedge clk);
            sp = tx;
            if (en) begin
                mon_frames++;
                check("tx_start_bit", 32'(st), 32'd0);
                check("tx_stop_bit", 32'(sp), 32'd1);
                if (tx_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL tx_unexpected_frame: got 0x%02h expected no frame", d);
                end else begin
                    e = tx_q.pop_front();
                    check("tx_byte", {23'd0, pb, d}, {23'd0, PAR & (^e), e});
                end
            end
            mon_busy = 1'b0;
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int lat, f0;

        vecs[0] = '{data: 8'h5A, stop: 1'b1, bad_par: 1'b0, glitch: 1'b0, exp_push: 1'b1, exp_ferr: 1'b0, exp_perr: 1'b0};
        vecs[1] = '{data: 8'h81, stop: 1'b0, bad_par: 1'b0, glitch: 1'b0, exp_push: 1'b0, exp_ferr: 1'b1, exp_perr: 1'b0};
        vecs[2] = '{data: 8'h00, stop: 1'b1, bad_par: 1'b0, glitch: 1'b1, exp_push: 1'b0, exp_ferr: 1'b0, exp_perr: 1'b0};
        vecs[3] = '{data: 8'hC3, stop: 1'b1, bad_par: 1'b1, glitch: 1'b0, exp_push: !PAR, exp_ferr: 1'b0, exp_perr: PAR};
        vecs[4] = '{data: 8'h7E, stop: 1'b1, bad_par: 1'b0, glitch: 1'b0, exp_push: 1'b1, exp_ferr: 1'b0, exp_perr: 1'b0};

        cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
        rx_drv = 1'b1; loop = 1'b0; mon_en = 1'b1; reset = 1'b1;
        wait_clks(3);
        reset = 1'b0;

        check("reset_tx", 32'(tx), 32'd1);
        reg_read(5'd0, r);
        check("reset_status", r, 32'h0000_0900);
        reg_read(5'd5, r);
        check("unmapped_addr", r, 32'd0);

        reg_write(5'd1, 32'd3);

        // single frame 0xA5 and push-to-start latency
        push_tx(8'hA5);
        lat = 0;
        while (tx !== 1'b0 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("tx_start_latency", 32'(lat <= 6 && tx === 1'b0), 32'd1);
        reg_read(5'd0, r);
        check("tx_busy_not_empty", r[11], 32'd0);
        wait_tx_drain(2000);
        reg_read(5'd0, r);
        check("tx_empty_after_frame", r, 32'h0000_0900);

        // fill TX FIFO while the line is busy; the 17th push must be dropped
        f0 = mon_frames;
        push_tx(8'h11);
        wait_clks(10);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) tx_q.push_back(8'h20 + 8'(i));
            reg_write(5'd2, 32'h20 + 32'(i));
        end
        reg_read(5'd0, r);
        check("tx_full_flag", r[9], 32'd1);
        check("tx_full_not_empty", r[11], 32'd0);
        wait_tx_drain(15000);
        wait_clks(800);
        check("tx_frame_count", 32'(mon_frames - f0), 32'd17);

        // loopback
        loop = 1'b1;
        foreach (vecs[i]) if (i < 3) begin end
        rx_q.push_back(8'h00); push_tx(8'h00);
        rx_q.push_back(8'hFF); push_tx(8'hFF);
        rx_q.push_back(8'h3C); push_tx(8'h3C);
        wait_tx_drain(5000);
        wait_clks(100);
        for (int i = 0; i < 3; i++) begin
            reg_read(5'd0, r);
            check($sformatf("loop%0d_rx_empty", i), r[8], 32'd0);
            check($sformatf("loop%0d_byte", i), {24'd0, r[7:0]}, {24'd0, rx_q.pop_front()});
            reg_write(5'd3, 32'd0);
        end
        reg_read(5'd0, r);
        check("loop_drained", r, 32'h0000_0900);
        loop = 1'b0;

        // RX vectors: good byte, frame error, glitch, parity case, good byte
        foreach (vecs[i]) begin
            if (vecs[i].exp_push) rx_q.push_back(vecs[i].data);
            if (vecs[i].glitch) begin
                rx_drv = 1'b0;
                wait_clks(12);
                rx_drv = 1'b1;
                wait_clks(3 * BIT_CLK);
            end else begin
                drive_frame(vecs[i].data, vecs[i].stop, vecs[i].bad_par);
            end
            reg_read(5'd0, r);
            check($sformatf("vec%0d_frame_err", i), r[12], 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_parity_err", i), r[13], 32'(vecs[i].exp_perr));
            check($sformatf("vec%0d_rx_empty", i), r[8], 32'(!vecs[i].exp_push));
            if (vecs[i].exp_push && rx_q.size() > 0) begin
                check($sformatf("vec%0d_byte", i), {24'd0, r[7:0]}, {24'd0, rx_q.pop_front()});
                reg_write(5'd3, 32'd0);
            end
            reg_write(5'd4, 32'd0);
        end
        rx_q.delete();
        reg_read(5'd0, r);
        check("after_vectors", r, 32'h0000_0900);

        // RX overrun: 16 frames fill the FIFO, the 17th is dropped
        for (int i = 0; i < 16; i++) begin
            rx_q.push_back(8'h40 + 8'(i));
            drive_frame(8'h40 + 8'(i), 1'b1, 1'b0);
        end
        reg_read(5'd0, r);
        check("rx_full_no_overrun", {r[10], r[8]}, 32'd0);
        drive_frame(8'hEE, 1'b1, 1'b0);
        reg_read(5'd0, r);
        check("overrun_set", r[10], 32'd1);
        check("overrun_head", {24'd0, r[7:0]}, {24'd0, rx_q[0]});
        reg_write(5'd4, 32'd0);
        reg_read(5'd0, r);
        check("overrun_cleared", r[10], 32'd0);
        for (int i = 0; i < 16; i++) begin
            reg_read(5'd0, r);
            check($sformatf("drain%0d_byte", i), {23'd0, r[8], r[7:0]}, {24'd0, rx_q.pop_front()});
            reg_write(5'd3, 32'd0);
        end
        reg_read(5'd0, r);
        check("rx_drained", r, 32'h0000_0900);
        reg_write(5'd3, 32'd0);
        reg_read(5'd0, r);
        check("pop_when_empty", r, 32'h0000_0900);

        // reset mid-frame clears flags and aborts the TX frame
        drive_frame(8'h81, 1'b0, 1'b0);
        reg_read(5'd0, r);
        check("ferr_before_reset", r[12], 32'd1);
        mon_en = 1'b0;
        reg_write(5'd2, 32'h55);
        lat = 0;
        while (tx !== 1'b0 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        wait_clks(30);
        check("tx_low_before_reset", 32'(tx), 32'd0);
        reset = 1'b1;
        wait_clks(1);
        check("reset_tx_abort", 32'(tx), 32'd1);
        reset = 1'b0;
        reg_read(5'd0, r);
        check("reset_status_again", r, 32'h0000_0900);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
